// File: rtl/cms_nvm_loader_if.sv
// Word-wide NVM read handshake between the mode-selection loader (master)
// and the non-volatile memory controller (slave).
interface cms_nvm_loader_if #(
  parameter int unsigned AW = 16
);
  logic          nvm_req;
  logic [AW-1:0] nvm_addr;
  logic          nvm_ack;
  logic          nvm_err;
  logic [31:0]   nvm_rdata;

  modport master (
    output nvm_req,
    output nvm_addr,
    input  nvm_ack,
    input  nvm_err,
    input  nvm_rdata
  );

  modport slave (
    input  nvm_req,
    input  nvm_addr,
    output nvm_ack,
    output nvm_err,
    output nvm_rdata
  );
endinterface

// File: rtl/cms_nvm_loader.sv
// Fetches the 128-bit chip-mode-selection word from NVM (primary + mirror copy),
// cross-checks the copies with bounded retries and hands the result to the decoder.
module cms_nvm_loader #(
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] PRIADDR  = '0,
  parameter logic [AW-1:0] MIRADDR  = AW'(16'h0010),
  parameter int unsigned   MAXRETRY = 2,
  parameter int unsigned   TOCYC    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  cms_nvm_loader_if.master    nvm,
  output logic [127:0]        cmsdata,
  output logic                cmsdatavld,
  output logic                cmsldbusy,
  output logic                cmslderr,
  output logic [1:0]          cmsldretry
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] CMP   = 3'd3;
  localparam logic [2:0] RETRY = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]   state;
  logic [1:0]   idx;
  logic         copy;
  logic         bad;
  logic [7:0]   waitcnt;
  logic [127:0] pri_buf;
  logic [127:0] mir_buf;

  assign nvm.nvm_req  = (state == REQ);
  assign nvm.nvm_addr = (state == REQ) ? ((copy ? MIRADDR : PRIADDR) + AW'(idx)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      copy       <= 1'b0;
      bad        <= 1'b0;
      waitcnt    <= '0;
      pri_buf    <= '0;
      mir_buf    <= '0;
      cmsdata    <= '0;
      cmsdatavld <= 1'b0;
      cmsldbusy  <= 1'b0;
      cmslderr   <= 1'b0;
      cmsldretry <= '0;
    end else begin
      cmsdatavld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            idx       <= '0;
            copy      <= 1'b0;
            bad       <= 1'b0;
            waitcnt   <= '0;
            cmsldbusy <= 1'b1;
          end
        end
        REQ: begin
          if (nvm.nvm_err) begin
            bad   <= 1'b1;
            state <= RETRY;
          end else if (nvm.nvm_ack) begin
            if (copy) mir_buf[{idx, 5'd0} +: 32] <= nvm.nvm_rdata;
            else      pri_buf[{idx, 5'd0} +: 32] <= nvm.nvm_rdata;
            // Last mirror word goes straight to CMP so the compare lands in cycle 16.
            if (copy && (idx == 2'd3)) state <= CMP;
            else                       state <= GAP;
          end else if (waitcnt == 8'(TOCYC)) begin
            bad   <= 1'b1;
            state <= RETRY;
          end else begin
            waitcnt <= waitcnt + 8'd1;
          end
        end
        GAP: begin
          if (idx == 2'd3) begin
            idx  <= '0;
            copy <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
          waitcnt <= '0;
          state   <= REQ;
        end
        CMP: begin
          if ((pri_buf == mir_buf) && !bad) begin
            cmsdata    <= pri_buf;
            cmsdatavld <= 1'b1;
            cmsldbusy  <= 1'b0;
            state      <= DONE;
          end else begin
            state <= RETRY;
          end
        end
        RETRY: begin
          if (cmsldretry < 2'(MAXRETRY)) begin
            cmsldretry <= cmsldretry + 2'd1;
            bad        <= 1'b0;
            idx        <= '0;
            copy       <= 1'b0;
            waitcnt    <= '0;
            state      <= REQ;
          end else begin
            // All-ones matches no defined mode pattern, so the decoder falls back.
            cmsdata    <= '1;
            cmslderr   <= 1'b1;
            cmsdatavld <= 1'b1;
            cmsldbusy  <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cms_nvm_loader.sv
// Scoreboard bench for cms_nvm_loader: directed loads against a scripted NVM model,
// results checked by monitors popping expectation queues.
module tb_cms_nvm_loader;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] cmsdata;
  logic         cmsdatavld;
  logic         cmsldbusy;
  logic         cmslderr;
  logic [1:0]   cmsldretry;

  cms_nvm_loader_if #(.AW(16)) nvm_bus ();

  cms_nvm_loader #(
    .AW(16), .PRIADDR(16'h0000), .MIRADDR(16'h0010), .MAXRETRY(2), .TOCYC(255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nvm        (nvm_bus),
    .cmsdata    (cmsdata),
    .cmsdatavld (cmsdatavld),
    .cmsldbusy  (cmsldbusy),
    .cmslderr   (cmslderr),
    .cmsldretry (cmsldretry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         err;
    logic [1:0]   retry;
    int           cyc;   // -1: latency not checked
  } exp_t;

  exp_t        sb[$];
  logic [15:0] addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_ref = 0;

  // NVM model configuration (written by the stimulus process only)
  logic [31:0] pri_mem[4];
  logic [31:0] mir_mem[4];
  int          wait_cyc    = 0;
  bit          never_ack   = 1'b0;
  int          corrupt     = 0;   // 0 none, 1 mirror word 2 on pass 0, 2 always
  bit          err_mode    = 1'b0;

  localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // NVM model: acks after wait_cyc idle request cycles, tracks the pass number.
  int  wcnt_m = 0;
  int  pass_m = -1;
  bit  prev_m = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      nvm_bus.nvm_ack   <= 1'b0;
      nvm_bus.nvm_err   <= 1'b0;
      nvm_bus.nvm_rdata <= '0;
      wcnt_m <= 0;
      pass_m <= -1;
      prev_m <= 1'b0;
    end else begin
      if (nvm_bus.nvm_req) begin
        if (!prev_m && nvm_bus.nvm_addr == 16'h0000) pass_m <= pass_m + 1;
        if (!never_ack && wcnt_m == wait_cyc) begin
          nvm_bus.nvm_ack <= 1'b1;
          nvm_bus.nvm_err <= err_mode && (pass_m == 0) && (nvm_bus.nvm_addr == 16'h0001);
          if (nvm_bus.nvm_addr < 16'h0010)
            nvm_bus.nvm_rdata <= pri_mem[nvm_bus.nvm_addr[1:0]];
          else if (nvm_bus.nvm_addr == 16'h0012 && (corrupt == 2 || (corrupt == 1 && pass_m == 0)))
            nvm_bus.nvm_rdata <= mir_mem[2] ^ 32'h0000_0100;
          else
            nvm_bus.nvm_rdata <= mir_mem[nvm_bus.nvm_addr[1:0]];
        end else begin
          nvm_bus.nvm_ack <= 1'b0;
          nvm_bus.nvm_err <= 1'b0;
          wcnt_m <= wcnt_m + 1;
        end
      end else begin
        nvm_bus.nvm_ack <= 1'b0;
        nvm_bus.nvm_err <= 1'b0;
        wcnt_m <= 0;
      end
      prev_m <= nvm_bus.nvm_req;
    end
  end

  // Address monitor: expected issue order plus stability while a request waits.
  bit          prev_a = 1'b0;
  logic [15:0] last_a = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_a <= 1'b0;
    end else begin
      if (nvm_bus.nvm_req && !prev_a && addr_q.size() > 0)
        check("addr_seq", nvm_bus.nvm_addr, addr_q.pop_front());
      if (nvm_bus.nvm_req && prev_a)
        check("addr_stable", nvm_bus.nvm_addr, last_a);
      prev_a <= nvm_bus.nvm_req;
      last_a <= nvm_bus.nvm_addr;
    end
  end

  // Result monitor: every cmsdatavld pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && cmsdatavld) begin
      if (sb.size() == 0) begin
        check("unexpected_vld", cmsdatavld, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cmsdata", cmsdata, e.data);
        check("cmslderr", cmslderr, e.err);
        check("cmsldretry", cmsldretry, e.retry);
        check("busy_at_vld", cmsldbusy, 1'b0);
        if (e.cyc >= 0) check("vld_cycle", cyc - start_ref, e.cyc);
      end
    end
  end

  task automatic set_mem(input logic [127:0] p, input logic [127:0] m);
    for (int unsigned i = 0; i < 4; i++) begin
      pri_mem[i] = p[32*i +: 32];
      mir_mem[i] = m[32*i +: 32];
    end
  endtask

  task automatic push_exp(input logic [127:0] d, input logic e, input logic [1:0] r, input int c);
    exp_t x;
    x.data = d; x.err = e; x.retry = r; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_cyc = 0; never_ack = 1'b0; corrupt = 0; err_mode = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    start_ref = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [127:0] final_data);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("vld_timeout", 1'b0, 1'b1);
      sb.delete();
    end
    // A second start must not restart a finished load.
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    check("busy_done", cmsldbusy, 1'b0);
    check("data_held", cmsdata, final_data);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_mem('0, '0);
    repeat (3) @(negedge clk);
    check("rst_req", nvm_bus.nvm_req, 1'b0);
    check("rst_addr", nvm_bus.nvm_addr, 16'h0000);
    check("rst_data", cmsdata, '0);
    check("rst_vld", cmsdatavld, 1'b0);
    check("rst_busy", cmsldbusy, 1'b0);
    check("rst_err", cmslderr, 1'b0);
    check("rst_retry", cmsldretry, 2'd0);
    reset = 1'b0;

    // 1: zero-wait, both copies zero
    set_mem('0, '0);
    foreach (addr_q[i]) addr_q.delete(i);
    addr_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0011, 16'h0012, 16'h0013};
    push_exp('0, 1'b0, 2'd0, 17);
    start_load();
    check("busy_running", cmsldbusy, 1'b1);
    wait_done(100, '0);
    check("addr_seq_done", addr_q.size(), 0);

    // 2: pattern, 3 wait cycles per access: 8x4 REQ + 7 GAP from cycle 1, CMP 40, vld 41
    do_reset();
    set_mem(PAT, PAT);
    wait_cyc = 3;
    push_exp(PAT, 1'b0, 2'd0, 41);
    start_load();
    wait_done(200, PAT);

    // 3: mirror word 2 corrupt on first pass only
    do_reset();
    set_mem(PAT, PAT);
    corrupt = 1;
    push_exp(PAT, 1'b0, 2'd1, 34);
    start_load();
    wait_done(200, PAT);

    // 4: persistent mismatch, three passes then fallback (final RETRY in 51)
    do_reset();
    set_mem(PAT, PAT);
    corrupt = 2;
    push_exp('1, 1'b1, 2'd2, 52);
    start_load();
    wait_done(300, '1);

    // 5: err with ack on primary word 1, pass 0: RETRY in 4, restart in 5, vld 21
    do_reset();
    set_mem(PAT, PAT);
    err_mode = 1'b1;
    push_exp(PAT, 1'b0, 2'd1, 21);
    start_load();
    wait_done(200, PAT);

    // 6: no ack ever, every pass times out
    do_reset();
    set_mem(PAT, PAT);
    never_ack = 1'b1;
    push_exp('1, 1'b1, 2'd2, -1);
    start_load();
    wait_done(1200, '1);

    // 7: reset during mirror read, then a clean load
    do_reset();
    set_mem(PAT, PAT);
    start_load();
    begin
      int n;
      n = 0;
      while (!(nvm_bus.nvm_req && nvm_bus.nvm_addr == 16'h0011) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reach_mirror", nvm_bus.nvm_addr, 16'h0011);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_req", nvm_bus.nvm_req, 1'b0);
    check("abort_busy", cmsldbusy, 1'b0);
    check("abort_data", cmsdata, '0);
    check("abort_vld", cmsdatavld, 1'b0);
    check("abort_retry", cmsldretry, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    push_exp(PAT, 1'b0, 2'd0, 17);
    start_load();
    wait_done(100, PAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
